// File: rtl/lzd_share_sched_pkg.sv
// rtl/lzd_share_sched_pkg.sv - shared constants and result type for the LZD sharing scheduler
package lzd_share_pkg;

  localparam int LZD_IN_W  = 61;
  localparam int LZD_POS_W = 6;
  localparam int LZD_ID_W  = 2;
  localparam logic [LZD_POS_W-1:0] LZD_ALL_ZERO = 6'd61;

  typedef struct packed {
    logic [LZD_ID_W-1:0]  id;
    logic [LZD_POS_W-1:0] pos;
  } lzd_rsp_t;

endpackage

// File: rtl/lzd_share_sched_if.sv
// rtl/lzd_share_sched_if.sv - lane request and tagged response bundle of the LZD scheduler
interface lzd_share_sched_if
  import lzd_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IN_W  = LZD_IN_W,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int POS_W = LZD_POS_W
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*IN_W-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [POS_W-1:0]      rsp_pos;
  logic                  rsp_zero;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_pos, rsp_zero
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_pos, rsp_zero
  );
endinterface

// File: rtl/lzd_share_sched_rsp_fifo.sv
// rtl/lzd_share_sched_rsp_fifo.sv - in-order result FIFO with registered storage
module lzd_rsp_fifo
  import lzd_share_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  lzd_rsp_t         push_data_i,
  input  logic             pop_i,
  output lzd_rsp_t         head_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lzd_rsp_t          mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_eff;

  assign pop_eff = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (push_i) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (pop_eff) rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({push_i, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  // Upstream credit must keep a push from ever landing on a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(push_i && count_q == CNT_W'(DEPTH)));
endmodule

// File: rtl/lzd_share_sched.sv
// rtl/lzd_share_sched.sv - round-robin sharing of one registered LZD among N_REQ lanes
module lzd_share_sched
  import lzd_share_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int IN_W      = LZD_IN_W,
  parameter int POS_W     = LZD_POS_W,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int RSP_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  lzd_share_sched_if.slave    bus,
  output logic                en_lzd,
  output logic [IN_W-1:0]     lzd_in,
  input  logic [POS_W-1:0]    zero_pos,
  output logic                busy
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0]  rr_q, rr_d, inflight_id_q, inflight_id_d, grant_idx;
  logic             inflight_v_q, inflight_v_d, grant_v, issue_ok, pop;
  logic [CNT_W-1:0] fifo_count;
  lzd_rsp_t         head, push_data;
  int               idx;

  // Credit looks only at registered state, so rsp_ready never reaches req_ready.
  assign issue_ok = (int'(fifo_count) + int'(inflight_v_q)) < RSP_DEPTH;

  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!rst && issue_ok) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant_v && bus.req_valid[idx]) begin
          grant_v   = 1'b1;
          grant_idx = ID_W'(idx);
        end
      end
    end
  end

  assign bus.req_ready = grant_v ? (N_REQ'(1) << grant_idx) : '0;
  assign en_lzd        = grant_v;
  assign lzd_in        = grant_v ? bus.req_data[int'(grant_idx)*IN_W +: IN_W] : '0;

  always_comb begin
    rr_d          = rr_q;
    inflight_v_d  = grant_v;
    inflight_id_d = inflight_id_q;
    if (grant_v) begin
      rr_d          = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      inflight_id_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q          <= '0;
      inflight_v_q  <= 1'b0;
      inflight_id_q <= '0;
    end else begin
      rr_q          <= rr_d;
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
    end
  end

  // zero_pos belongs to the op issued last cycle; the credit guarantees room for it.
  assign push_data = '{id: LZD_ID_W'(inflight_id_q), pos: zero_pos};
  assign pop       = bus.rsp_valid & bus.rsp_ready;

  lzd_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_v_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_id    = ID_W'(head.id);
  assign bus.rsp_pos   = head.pos;
  assign bus.rsp_zero  = (head.pos == LZD_ALL_ZERO);
  assign busy          = inflight_v_q | bus.rsp_valid;
endmodule

// File: tb/tb_lzd_share_sched.sv
// tb/tb_lzd_share_sched.sv - directed bench for the LZD sharing scheduler with a behavioural LZD
module tb_lzd_share_sched;
  import lzd_share_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_lzd;
  logic [60:0] lzd_in;
  logic [5:0]  zero_pos;
  logic        busy;
  int          tests_run = 0;
  int          tests_failed = 0;

  lzd_share_sched_if #(.N_REQ(4)) bus ();

  lzd_share_sched #(.N_REQ(4), .RSP_DEPTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .en_lzd   (en_lzd),
    .lzd_in   (lzd_in),
    .zero_pos (zero_pos),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lzc64(input logic [63:0] v);
    logic [5:0] r;
    logic       found;
    r = 6'd63;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && v[i]) begin
        r = 6'(63 - i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Registered LZD beside the scheduler: operand padded with 3'b111, cleared when idle.
  always_ff @(posedge clk) begin
    zero_pos <= en_lzd ? lzc64({lzd_in, 3'b111}) : 6'd0;
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.req_ready !== 4'h0) begin tests_failed++; $display("FAIL reset_req_ready got=%h exp=0", bus.req_ready); end
    tests_run++;
    if (en_lzd !== 1'b0) begin tests_failed++; $display("FAIL reset_en_lzd got=%b exp=0", en_lzd); end
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle rsp_valid=%b busy=%b exp=0,0", bus.rsp_valid, busy); end
    bus.req_valid = 4'h0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req_data[0 +: 61] = 61'h1;
    bus.req_valid = 4'b0001;
    #1;
    tests_run++;
    if (bus.req_ready !== 4'b0001 || en_lzd !== 1'b1 || lzd_in !== 61'h1) begin
      tests_failed++; $display("FAIL single_issue ready=%h en=%b in=%h exp=1,1,1", bus.req_ready, en_lzd, lzd_in);
    end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    tests_run++;
    if (en_lzd !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL single_t1 en=%b rsp_valid=%b busy=%b exp=0,0,1", en_lzd, bus.rsp_valid, busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_pos !== 6'd60 || bus.rsp_zero !== 1'b0) begin
      tests_failed++; $display("FAIL single_rsp v=%b id=%0d pos=%0d z=%b exp=1,0,60,0", bus.rsp_valid, bus.rsp_id, bus.rsp_pos, bus.rsp_zero);
    end
    @(negedge clk);
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_drain rsp_valid=%b busy=%b exp=0,0", bus.rsp_valid, busy);
    end
  endtask

  task automatic test_lzd_values();
    logic [60:0] ops  [3];
    logic [5:0]  exps [3];
    logic        zs   [3];
    ops[0] = 61'h0;                   exps[0] = 6'd61; zs[0] = 1'b1;
    ops[1] = 61'h1000_0000_0000_0000; exps[1] = 6'd0;  zs[1] = 1'b0;
    ops[2] = 61'h0FFF_FFFF_FFFF_FFFF; exps[2] = 6'd1;  zs[2] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.req_data[3*61 +: 61] = ops[n];
      bus.req_valid = 4'b1000;
      #1;
      tests_run++;
      if (bus.req_ready !== 4'b1000) begin tests_failed++; $display("FAIL values_grant%0d got=%h exp=8", n, bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_pos !== exps[n] || bus.rsp_zero !== zs[n]) begin
        tests_failed++;
        $display("FAIL values_rsp%0d v=%b id=%0d pos=%0d z=%b exp=1,3,%0d,%b", n, bus.rsp_valid, bus.rsp_id, bus.rsp_pos, bus.rsp_zero, exps[n], zs[n]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) bus.req_data[i*61 +: 61] = 61'h1 << (10 * i);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) begin
        tests_run++;
        if (bus.req_ready !== (4'b0001 << (k % 4)) || en_lzd !== 1'b1) begin
          tests_failed++; $display("FAIL rr_grant%0d got=%h en=%b exp=%h", k, bus.req_ready, en_lzd, 4'b0001 << (k % 4));
        end
      end
      if (k >= 2) begin
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((k - 2) % 4) || bus.rsp_pos !== 6'(60 - 10 * ((k - 2) % 4))) begin
          tests_failed++;
          $display("FAIL rr_rsp%0d v=%b id=%0d pos=%0d exp=1,%0d,%0d", k, bus.rsp_valid, bus.rsp_id, bus.rsp_pos, (k - 2) % 4, 60 - 10 * ((k - 2) % 4));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] vtab [10];
    logic [3:0] rtab [10];
    int         idt  [10];
    vtab = '{4'hF, 4'hF, 4'hF, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    rtab = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
    idt  = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.req_valid = vtab[k];
      bus.rsp_ready = (k >= 5);
      #1;
      tests_run++;
      if (bus.req_ready !== rtab[k] || en_lzd !== (rtab[k] != 4'h0)) begin
        tests_failed++; $display("FAIL bp_grant%0d got=%h en=%b exp=%h", k, bus.req_ready, en_lzd, rtab[k]);
      end
      tests_run++;
      if (idt[k] < 0) begin
        if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_rsp%0d v=%b exp=0", k, bus.rsp_valid); end
      end else if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(idt[k]) || bus.rsp_pos !== 6'(60 - 10 * idt[k])) begin
        tests_failed++;
        $display("FAIL bp_rsp%0d v=%b id=%0d pos=%0d exp=1,%0d,%0d", k, bus.rsp_valid, bus.rsp_id, bus.rsp_pos, idt[k], 60 - 10 * idt[k]);
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_midflight();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid = 4'hF;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 4'h0 || en_lzd !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_gate ready=%h en=%b exp=0,0", bus.req_ready, en_lzd);
    end
    @(negedge clk);
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_clear rsp_valid=%b busy=%b exp=0,0", bus.rsp_valid, busy);
    end
    rst = 1'b0;
    bus.req_valid = 4'b1100;
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL rstmid_rrptr got=%h exp=4", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_pos !== 6'd40) begin
      tests_failed++; $display("FAIL rstmid_rsp v=%b id=%0d pos=%0d exp=1,2,40", bus.rsp_valid, bus.rsp_id, bus.rsp_pos);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [3:0] v;
    int         waits = 0;
    bit         got = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      v = {1'($urandom), 1'($urandom), 1'b1, 1'($urandom)};
      bus.req_valid = v;
      #1;
      tests_run++;
      if (!$onehot(bus.req_ready) || (bus.req_ready & ~v) != 4'h0 || en_lzd !== (bus.req_ready != 4'h0)) begin
        tests_failed++; $display("FAIL fair_grant%0d ready=%h valid=%h en=%b exp=onehot_within_valid", k, bus.req_ready, v, en_lzd);
      end
      if (bus.req_ready[1]) got = 1'b1;
      else waits++;
    end
    tests_run++;
    if (!got || waits > 3) begin tests_failed++; $display("FAIL fair_wait got=%0d granted=%b exp<=3,1", waits, got); end
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    tests_run++;
    if (en_lzd !== 1'b0) begin tests_failed++; $display("FAIL fair_noissue en=%b exp=0", en_lzd); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL fair_drain busy=%b rsp_valid=%b exp=0,0", busy, bus.rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lzd_values();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
